// File: rtl/clk_div_multi.sv
// Multi-channel integer clock divider with glitch-free ratio/enable changes at period boundaries.
// Optional CLK_DIV_SYNC_EN adds i_sync, which restarts every running channel in the same cycle.
module clk_div_multi #(
  parameter int NUM_CH  = 2,
  parameter int RATIO_W = 8
) (
  input  logic                      i_ref_clk,
  input  logic                      i_rst,
`ifdef CLK_DIV_SYNC_EN
  input  logic                      i_sync,
`endif
  input  logic [NUM_CH-1:0]         i_clk_en,
  input  logic [NUM_CH*RATIO_W-1:0] i_div_ratio,
  output logic [NUM_CH-1:0]         o_div_clk,
  output logic [NUM_CH-1:0]         o_edge_stb,
  output logic [NUM_CH-1:0]         o_active
);

  typedef enum logic {
    ST_BYPASS = 1'b0,
    ST_RUN    = 1'b1
  } state_e;

  logic sync_w;
`ifdef CLK_DIV_SYNC_EN
  assign sync_w = i_sync;
`else
  assign sync_w = 1'b0;
`endif

  // Holds pass-through low for the first cycle after reset releases.
  logic bypass_ok_d, bypass_ok_q;
  assign bypass_ok_d = 1'b1;

  always_ff @(posedge i_ref_clk) begin
    if (i_rst) bypass_ok_q <= 1'b0;
    else       bypass_ok_q <= bypass_ok_d;
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    state_e             state_d, state_q;
    logic [RATIO_W-1:0] cnt_d, cnt_q;
    logic [RATIO_W-1:0] ratio_d, ratio_q;
    logic               div_d, div_q;
    logic               stb_d, stb_q;
    logic               run_d, run_q;

    logic [RATIO_W-1:0] ratio_in;
    logic [RATIO_W-1:0] half;
    logic [RATIO_W-1:0] cnt_inc;
    logic               start_ok;
    logic               boundary;

    assign ratio_in = i_div_ratio[k*RATIO_W +: RATIO_W];
    assign start_ok = i_clk_en[k] && (ratio_in >= RATIO_W'(2));
    assign half     = ratio_q >> 1;
    assign cnt_inc  = cnt_q + RATIO_W'(1);
    assign boundary = (cnt_q == ratio_q - RATIO_W'(1));

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ratio_d = ratio_q;
      div_d   = div_q;
      stb_d   = stb_q;
      run_d   = run_q;
      unique case (state_q)
        ST_BYPASS: begin
          stb_d = 1'b0;
          div_d = 1'b0;
          if (start_ok) begin
            state_d = ST_RUN;
            ratio_d = ratio_in;
            cnt_d   = '0;
            div_d   = 1'b1;
            stb_d   = 1'b1;
            run_d   = 1'b1;
          end
        end
        ST_RUN: begin
          // Inputs are only looked at when a period ends (or on a sync restart).
          if (boundary || sync_w) begin
            if (start_ok) begin
              ratio_d = ratio_in;
              cnt_d   = '0;
              div_d   = 1'b1;
              stb_d   = 1'b1;
            end else begin
              state_d = ST_BYPASS;
              cnt_d   = '0;
              run_d   = 1'b0;
              div_d   = 1'b0;
              stb_d   = 1'b0;
            end
          end else begin
            cnt_d = cnt_inc;
            div_d = (cnt_inc < half);
            stb_d = 1'b0;
          end
        end
        default: begin
          state_d = ST_BYPASS;
          run_d   = 1'b0;
          div_d   = 1'b0;
          stb_d   = 1'b0;
        end
      endcase
    end

    always_ff @(posedge i_ref_clk) begin
      if (i_rst) begin
        state_q <= ST_BYPASS;
        cnt_q   <= '0;
        ratio_q <= '0;
        div_q   <= 1'b0;
        stb_q   <= 1'b0;
        run_q   <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        ratio_q <= ratio_d;
        div_q   <= div_d;
        stb_q   <= stb_d;
        run_q   <= run_d;
      end
    end

    assign o_div_clk[k]  = run_q ? div_q : (bypass_ok_q & i_ref_clk);
    assign o_edge_stb[k] = stb_q;
    assign o_active[k]   = run_q;
  end

endmodule

// File: tb/tb_clk_div_multi.sv
// Bench for clk_div_multi: random stimulus, queue-based period model, scoreboard monitor.
module tb_clk_div_multi;
  localparam int NUM_CH  = 2;
  localparam int RATIO_W = 8;
  localparam int W       = 3 * NUM_CH;

  // Clock/reset block
  logic ref_clk = 1'b0;
  logic rst     = 1'b1;
  logic [NUM_CH-1:0]         clk_en    = '0;
  logic [NUM_CH*RATIO_W-1:0] div_ratio = '0;
`ifdef CLK_DIV_SYNC_EN
  logic sync = 1'b0;
`endif
  logic [NUM_CH-1:0] div_clk, edge_stb, active;

  always #5 ref_clk = ~ref_clk;

  clk_div_multi #(.NUM_CH(NUM_CH), .RATIO_W(RATIO_W)) dut (
    .i_ref_clk   (ref_clk),
    .i_rst       (rst),
`ifdef CLK_DIV_SYNC_EN
    .i_sync      (sync),
`endif
    .i_clk_en    (clk_en),
    .i_div_ratio (div_ratio),
    .o_div_clk   (div_clk),
    .o_edge_stb  (edge_stb),
    .o_active    (active)
  );

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  // Reference model: each running channel holds a queue with the remaining
  // output levels of its current period; an empty queue means the period ended.
  bit                m_run [NUM_CH];
  bit                m_div [NUM_CH];
  bit                m_stb [NUM_CH];
  bit                m_bypass_ok;
  bit                sched [NUM_CH][$];

  always @(posedge ref_clk) begin : model
    int n;
    bit go;
    bit resample;
    logic [NUM_CH-1:0] e_act, e_stb, e_div;
    if (rst) begin
      m_bypass_ok = 1'b0;
      for (int k = 0; k < NUM_CH; k++) begin
        m_run[k] = 1'b0; m_div[k] = 1'b0; m_stb[k] = 1'b0;
        sched[k].delete();
      end
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        n  = int'(div_ratio[k*RATIO_W +: RATIO_W]);
        go = clk_en[k] && (n >= 2);
        resample = !m_run[k] || (sched[k].size() == 0);
`ifdef CLK_DIV_SYNC_EN
        if (sync && m_run[k]) resample = 1'b1;
`endif
        m_stb[k] = 1'b0;
        if (resample) begin
          sched[k].delete();
          if (go) begin
            for (int i = 0; i < n; i++) sched[k].push_back(i < n / 2);
            m_run[k] = 1'b1;
            m_stb[k] = 1'b1;
          end else begin
            m_run[k] = 1'b0;
            m_div[k] = 1'b0;
          end
        end
        if (m_run[k]) m_div[k] = sched[k].pop_front();
      end
      m_bypass_ok = 1'b1;
    end
    for (int k = 0; k < NUM_CH; k++) begin
      e_act[k] = m_run[k];
      e_stb[k] = m_stb[k];
      // Sampled while ref_clk is high, so bypass shows the reference level.
      e_div[k] = m_run[k] ? m_div[k] : m_bypass_ok;
    end
    exp_q.push_back({e_act, e_stb, e_div});
  end

  // Scoreboard monitor
  always begin : monitor
    logic [W-1:0] exp_v;
    logic [W-1:0] got_v;
    logic [NUM_CH-1:0] exp_low;
    @(posedge ref_clk);
    #1;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL no_expected t=%0t got=%b required=one queued entry", $time,
               {active, edge_stb, div_clk});
    end else begin
      exp_v = exp_q.pop_front();
      got_v = {active, edge_stb, div_clk};
      if (got_v !== exp_v) begin
        errors++;
        $display("FAIL out_high t=%0t {act,stb,div} got=%b required=%b", $time, got_v, exp_v);
      end
      @(negedge ref_clk);
      #1;
      exp_low = exp_v[W-1 -: NUM_CH] & exp_v[NUM_CH-1:0];
      checks++;
      if (div_clk !== exp_low) begin
        errors++;
        $display("FAIL div_low t=%0t got=%b required=%b", $time, div_clk, exp_low);
      end
    end
  end

  // Driver tasks
  task automatic step(input int n);
    repeat (n) @(negedge ref_clk);
  endtask

  task automatic set_ch(input int k, input bit en, input int n);
    clk_en[k] = en;
    div_ratio[k*RATIO_W +: RATIO_W] = RATIO_W'(n);
  endtask

  initial begin : stimulus
    int k;
    rst = 1'b1;
    step(3);
    rst = 1'b0;
    step(2);
    set_ch(0, 1'b1, 2);  step(12);
    set_ch(1, 1'b1, 5);  step(20);
    set_ch(0, 1'b1, 4);  step(9);
    set_ch(0, 1'b1, 3);  step(12);
    set_ch(0, 1'b1, 6);  step(8);
    set_ch(0, 1'b0, 6);  step(12);
    set_ch(0, 1'b1, 1);  step(5);
    set_ch(0, 1'b1, 0);  step(5);
    set_ch(1, 1'b1, 8);  step(11);
    rst = 1'b1;          step(2);
    rst = 1'b0;          step(4);
`ifdef CLK_DIV_SYNC_EN
    set_ch(0, 1'b1, 4);  step(3);
    set_ch(1, 1'b1, 6);  step(7);
    sync = 1'b1;         step(1);
    sync = 1'b0;         step(30);
`endif
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 7) == 0) begin
        k = int'($urandom_range(0, NUM_CH - 1));
        if ($urandom_range(0, 15) == 0)
          set_ch(k, $urandom_range(0, 3) != 0, int'($urandom_range(0, 255)));
        else
          set_ch(k, $urandom_range(0, 3) != 0, int'($urandom_range(0, 12)));
      end
`ifdef CLK_DIV_SYNC_EN
      sync = ($urandom_range(0, 19) == 0);
`endif
      rst = ($urandom_range(0, 199) == 0);
      step(1);
    end
    rst = 1'b0;
    step(4);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
